// File: rtl/signed_div_pipe_pkg.sv
// Shared ALU constants and helpers for the signed/unsigned divide pipeline.
// Latency: none (package only).
// Backpressure: not applicable.
package signed_div_pipe_pkg;

    localparam int                DATA_W         = 16;
    localparam logic [DATA_W-1:0] DIV_ZERO_Q_DEF = 16'hFFFF;
    localparam logic [DATA_W-1:0] SIGNED_MIN     = 16'h8000;

    // Two's-complement negate without width-extension surprises.
    function automatic logic [DATA_W-1:0] neg(input logic [DATA_W-1:0] v);
        return {DATA_W{1'b0}} - v;
    endfunction

    // Magnitude of a value; in unsigned mode the raw bits are the magnitude.
    // The signed minimum maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? neg(v) : v;
    endfunction

endpackage

// File: rtl/signed_div_pipe_udiv.sv
// Unsigned 16-bit restoring divider, purely combinational.
// Latency: 0 cycles (sits between two register stages).
// Backpressure: none; outputs follow inputs.
module signed_div_pipe_udiv
    import signed_div_pipe_pkg::*;
(
    input  logic [DATA_W-1:0] num,
    input  logic [DATA_W-1:0] den,
    output logic [DATA_W-1:0] quo,
    output logic [DATA_W-1:0] rem
);

    logic [DATA_W:0] acc;

    // Shift-subtract long division, one quotient bit per dividend bit, MSB first.
    always_comb begin
        acc = '0;
        quo = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            acc = {acc[DATA_W-1:0], num[i]};
            if (acc >= {1'b0, den}) begin
                acc    = acc - {1'b0, den};
                quo[i] = 1'b1;
            end
        end
        rem = acc[DATA_W-1:0];
    end

endmodule

// File: rtl/signed_div_pipe.sv
// Signed/unsigned 16-bit divider: operand-prep stage A, combinational divide, result stage B.
// Latency: 2 cycles from input transfer to out_valid; one result per cycle when unstalled.
// Backpressure: B holds while out_valid && !out_ready; A holds behind B; in_ready = A can advance.
module signed_div_pipe
    import signed_div_pipe_pkg::*;
#(
    parameter logic [DATA_W-1:0] DIV_ZERO_Q = DIV_ZERO_Q_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic [DATA_W-1:0] in_dividend,
    input  logic [DATA_W-1:0] in_divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quotient,
    output logic [DATA_W-1:0] out_remainder,
    output logic              out_div_zero,
    output logic              out_overflow
);

    // Stage A: magnitudes, sign fixups, exception flags, raw dividend for the div-zero remainder.
    logic              a_vld_q,  a_vld_d;
    logic [DATA_W-1:0] a_num_q,  a_num_d;
    logic [DATA_W-1:0] a_den_q,  a_den_d;
    logic [DATA_W-1:0] a_raw_q,  a_raw_d;
    logic              a_qneg_q, a_qneg_d;
    logic              a_rneg_q, a_rneg_d;
    logic              a_dz_q,   a_dz_d;
    logic              a_ovf_q,  a_ovf_d;

    // Stage B: final result as presented on the output port.
    logic              b_vld_q,  b_vld_d;
    logic [DATA_W-1:0] b_quo_q,  b_quo_d;
    logic [DATA_W-1:0] b_rem_q,  b_rem_d;
    logic              b_dz_q,   b_dz_d;
    logic              b_ovf_q,  b_ovf_d;

    logic              b_adv;
    logic              a_adv;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;

    signed_div_pipe_udiv u_udiv (
        .num (a_num_q),
        .den (a_den_q),
        .quo (div_quo),
        .rem (div_rem)
    );

    // Advance conditions: B drains or is empty; A moves whenever it is empty or B moves.
    always_comb begin
        b_adv = !b_vld_q || out_ready;
        a_adv = !a_vld_q || b_adv;
    end

    // Stage A next state: capture a new request only on an input transfer, otherwise hold data.
    always_comb begin
        a_vld_d  = a_adv ? in_valid : a_vld_q;
        a_num_d  = a_num_q;
        a_den_d  = a_den_q;
        a_raw_d  = a_raw_q;
        a_qneg_d = a_qneg_q;
        a_rneg_d = a_rneg_q;
        a_dz_d   = a_dz_q;
        a_ovf_d  = a_ovf_q;
        if (a_adv && in_valid) begin
            a_num_d  = mag(in_dividend, in_signed);
            a_den_d  = mag(in_divisor, in_signed);
            a_raw_d  = in_dividend;
            a_qneg_d = in_signed && (in_dividend[DATA_W-1] ^ in_divisor[DATA_W-1]);
            a_rneg_d = in_signed && in_dividend[DATA_W-1];
            a_dz_d   = (in_divisor == '0);
            a_ovf_d  = in_signed && (in_dividend == SIGNED_MIN) && (in_divisor == '1);
        end
    end

    // Stage B next state: sign-correct the divider outputs, then apply exception overrides.
    always_comb begin
        b_vld_d = b_adv ? a_vld_q : b_vld_q;
        b_quo_d = b_quo_q;
        b_rem_d = b_rem_q;
        b_dz_d  = b_dz_q;
        b_ovf_d = b_ovf_q;
        if (b_adv && a_vld_q) begin
            b_quo_d = a_qneg_q ? neg(div_quo) : div_quo;
            b_rem_d = a_rneg_q ? neg(div_rem) : div_rem;
            b_dz_d  = a_dz_q;
            b_ovf_d = a_ovf_q;
            if (a_dz_q) begin
                b_quo_d = DIV_ZERO_Q;
                b_rem_d = a_raw_q;
                b_ovf_d = 1'b0;
            end else if (a_ovf_q) begin
                b_quo_d = SIGNED_MIN;
                b_rem_d = '0;
            end
        end
    end

    // Pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q  <= 1'b0;
            a_num_q  <= '0;
            a_den_q  <= '0;
            a_raw_q  <= '0;
            a_qneg_q <= 1'b0;
            a_rneg_q <= 1'b0;
            a_dz_q   <= 1'b0;
            a_ovf_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            b_quo_q  <= '0;
            b_rem_q  <= '0;
            b_dz_q   <= 1'b0;
            b_ovf_q  <= 1'b0;
        end else begin
            a_vld_q  <= a_vld_d;
            a_num_q  <= a_num_d;
            a_den_q  <= a_den_d;
            a_raw_q  <= a_raw_d;
            a_qneg_q <= a_qneg_d;
            a_rneg_q <= a_rneg_d;
            a_dz_q   <= a_dz_d;
            a_ovf_q  <= a_ovf_d;
            b_vld_q  <= b_vld_d;
            b_quo_q  <= b_quo_d;
            b_rem_q  <= b_rem_d;
            b_dz_q   <= b_dz_d;
            b_ovf_q  <= b_ovf_d;
        end
    end

    assign in_ready      = a_adv;
    assign out_valid     = b_vld_q;
    assign out_quotient  = b_quo_q;
    assign out_remainder = b_rem_q;
    assign out_div_zero  = b_dz_q;
    assign out_overflow  = b_ovf_q;

endmodule

// File: tb/tb_signed_div_pipe.sv
// Bench for signed_div_pipe: directed corner cases, backpressure, reset flush, randomized traffic.
// Expected results come from plain integer arithmetic on the operands, queued in request order.
// Output port is checked on every transfer; stalled outputs are checked for stability.
module tb_signed_div_pipe;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [15:0] in_dividend = '0;
    logic [15:0] in_divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_quotient;
    logic [15:0] out_remainder;
    logic        out_div_zero;
    logic        out_overflow;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   xfer_cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   stall_prev = 1'b0;
    res_t stall_val;
    res_t exp_q[$];

    signed_div_pipe #(.DIV_ZERO_Q(16'hFFFF)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_signed     (in_signed),
        .in_dividend   (in_dividend),
        .in_divisor    (in_divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_quotient  (out_quotient),
        .out_remainder (out_remainder),
        .out_div_zero  (out_div_zero),
        .out_overflow  (out_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: integer division truncating toward zero, remainder takes dividend's sign.
    function automatic res_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
        res_t e;
        int   ai;
        int   bi;
        e = '0;
        if (b == 16'h0000) begin
            e.q  = 16'hFFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
            if (ai == -32768 && bi == -1) begin
                e.q   = 16'h8000;
                e.r   = 16'h0000;
                e.ovf = 1'b1;
            end else begin
                e.q = 16'(ai / bi);
                e.r = 16'(ai % bi);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(0, 15));
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic res_t out_now();
        return {out_quotient, out_remainder, out_div_zero, out_overflow};
    endfunction

    // Scoreboard: record accepted requests, compare every output transfer, check stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_result got=%h", out_now());
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    assert (out_now() === e) else begin
                        errors++;
                        $error("FAIL result got q=%h r=%h dz=%b ovf=%b exp q=%h r=%h dz=%b ovf=%b",
                               out_quotient, out_remainder, out_div_zero, out_overflow,
                               e.q, e.r, e.dz, e.ovf);
                    end
                end
            end
            if (stall_prev && out_valid) begin
                checks++;
                assert (out_now() === stall_val) else begin
                    errors++;
                    $error("FAIL stall_stable got=%h exp=%h", out_now(), stall_val);
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = out_now();
            if (in_valid && in_ready)
                exp_q.push_back(model(in_signed, in_dividend, in_divisor));
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request and hold it until accepted (bounded); returns 1 ns after the transfer edge.
    task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b);
        bit got;
        got         = 1'b0;
        in_valid    = 1'b1;
        in_signed   = s;
        in_dividend = a;
        in_divisor  = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_accept", {31'd0, got}, 32'd1);
        xfer_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        // Reset state
        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient",  {16'd0, out_quotient}, 32'd0);
        chk("rst_remainder", {16'd0, out_remainder}, 32'd0);
        chk("rst_div_zero",  {31'd0, out_div_zero}, 32'd0);
        chk("rst_overflow",  {31'd0, out_overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency of a single unsigned request: 100 / 7
        out_ready = 1'b1;
        send(1'b0, 16'd100, 16'd7);
        in_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - xfer_cyc;
                break;
            end
        end
        chk("latency", lat, 32'd2);
        chk("q_100_7", {16'd0, out_quotient}, 32'd14);
        chk("r_100_7", {16'd0, out_remainder}, 32'd2);
        @(posedge clk);
        #1;

        // Directed sign, overflow and divide-by-zero cases, back to back
        send(1'b1, 16'hFFF9, 16'h0002);
        send(1'b1, 16'h0007, 16'hFFFE);
        send(1'b1, 16'h8000, 16'hFFFF);
        send(1'b0, 16'h8000, 16'hFFFF);
        send(1'b1, 16'h1234, 16'h0000);
        send(1'b0, 16'h1234, 16'h0000);
        send(1'b1, 16'h8000, 16'h0001);
        send(1'b0, 16'hFFFF, 16'h0001);
        drain();

        // Backpressure: two accepted, third blocked for 5 cycles, then all four emerge in order
        out_ready = 1'b0;
        send(1'b0, 16'd1000, 16'd3);
        send(1'b1, 16'hFC18, 16'd7);
        in_valid    = 1'b1;
        in_signed   = 1'b1;
        in_dividend = 16'd500;
        in_divisor  = 16'hFFF6;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b1, 16'd500, 16'hFFF6);
        send(1'b0, 16'd65535, 16'd255);
        drain();

        // Randomized traffic with random consumer stalls
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(1'($urandom_range(0, 1)), pick(), pick());
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        #2;
        drain();

        // Reset with both stages full: outputs clear at once, nothing stale afterwards
        out_ready = 1'b0;
        send(1'b0, 16'd77, 16'd5);
        send(1'b0, 16'd99, 16'd4);
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_before_rst", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_quot",  {16'd0, out_quotient}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #1;
        send(1'b1, 16'hFFF9, 16'h0002);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_div_pipe.md
SIGNED_DIV_PIPE -- requirements
Module: signed_div_pipe

Interface
REQ-001 Parameter: DIV_ZERO_Q, default 16'hFFFF, quotient returned on divide-by-zero.
REQ-002 Ports SHALL be, in this order:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: operand request valid.
- in_ready, output, 1: block accepts request this cycle.
- in_signed, input, 1: 1 = two's-complement divide, 0 = unsigned.
- in_dividend, input, 16: dividend.
- in_divisor, input, 16: divisor.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts result.
- out_quotient, output, 16: quotient.
- out_remainder, output, 16: remainder.
- out_div_zero, output, 1: divisor was zero.
- out_overflow, output, 1: signed 16'h8000 / 16'hFFFF case.
REQ-003 Clocking and reset SHALL be: one clock (clk); reset rst_n asynchronous, active-low.

Function
REQ-004 Handshakes: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready; valid-ready semantics.
REQ-005 Two registered stages: A (operand prep) and B (result). The 16-bit combinational unsigned divider sits between them.
REQ-006 Stage A SHALL capture per transfer:
- magnitudes |dividend|, |divisor| (16'h8000 maps to 16'h8000 unsigned);
- sign flags: quotient negative = dividend[15] ^ divisor[15]; remainder negative = dividend[15]; both forced 0 when in_signed=0;
- flags div_zero (divisor==0) and overflow (in_signed && dividend==16'h8000 && divisor==16'hFFFF).
REQ-007 Stage B SHALL load the sign-corrected divider outputs (two's-complement negate where the flag is set).
REQ-008 Divide-by-zero overrides: quotient=DIV_ZERO_Q, remainder=original dividend, out_div_zero=1, out_overflow=0.
REQ-009 Overflow overrides: quotient=16'h8000, remainder=16'h0000, out_overflow=1.
REQ-010 Results SHALL satisfy: dividend == quotient*divisor + remainder (mod 2^16); |remainder| < |divisor| for all non-zero divisors.
REQ-011 Latency SHALL be exactly 2 cycles from input transfer to out_valid when unstalled; throughput 1 result per cycle.
REQ-012 Flow control: stage B advances when !out_valid || out_ready; stage A advances when stage A is empty or stage B advances; in_ready equals stage A's advance condition (combinational, no dependence on in_valid).
REQ-013 Stalled stages SHALL hold all data and flags stable; out_* stable while out_valid && !out_ready.
REQ-014 Simultaneous output and input transfers in a full pipe SHALL move both stages with no bubble and no loss.
REQ-015 Results SHALL leave in request order; no reordering or duplication.

Reset
REQ-016 Reset assertion (async) SHALL clear both stage valid bits immediately, discarding in-flight requests.
REQ-017 Reset values: out_valid=0, out_quotient=0, out_remainder=0, out_div_zero=0, out_overflow=0. in_ready SHALL be 1 from the first edge after deassertion.
REQ-018 Reset mid-operation: no stale result SHALL appear after deassertion.

Structure
REQ-019 A shared ALU package SHALL hold the data width constant (16), the DIV_ZERO_Q default, and the signed-minimum constant 16'h8000.
REQ-020 The existing 16-bit unsigned combinational divider SHALL be the single instantiated sub-module; no other hierarchy.

Verification
REQ-021 Unsigned 16'd100 / 16'd7: out_quotient=14, out_remainder=2, out_valid 2 cycles after transfer.
REQ-022 Signed 16'hFFF9 / 16'h0002 (-7/2): quotient=16'hFFFD, remainder=16'hFFFF; 16'h0007 / 16'hFFFE: quotient=16'hFFFD, remainder=16'h0001.
REQ-023 Signed 16'h8000 / 16'hFFFF: quotient=16'h8000, remainder=0, out_overflow=1; the same operands unsigned: quotient=0, remainder=16'h8000, flag 0.
REQ-024 16'h1234 / 0 (signed and unsigned): quotient=16'hFFFF, remainder=16'h1234, out_div_zero=1.
REQ-025 Backpressure: 4 back-to-back requests with out_ready=0 for 5 cycles: in_ready drops after 2 accepted; after release, all 4 results emerge in order with no loss.
REQ-026 Reset mid-operation: rst_n low for 1 cycle with both stages full: out_valid drops asynchronously; no stale result after deassertion.
